// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream into
// 32-bit little-endian words and holds the CPU in reset until loaded.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_t                state;
  state_t                next;
  logic [15:0]           n;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            bcnt;
  logic [31:0]           word;

  logic [15:0] len;
  logic        last;

  assign len  = {byte_data, n[7:0]};
  assign last = (16'(idx) == n - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len == 16'd0)             next = DONE;
          else if ({1'b0, len} > CAP)   next = ERR;
          else                          next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && bcnt == 2'd3) next = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = word;
        next      = last ? DONE : DATA;
      end
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) next = LEN_LO;
      end
      ERR: begin
        error = 1'b1;
        if (start) next = LEN_LO;
      end
      default: next = IDLE;
    endcase
  end

  // Bytes shift in from the top so the first byte lands in [7:0]
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n    <= '0;
      idx  <= '0;
      bcnt <= '0;
      word <= '0;
    end else begin
      unique case (state)
        LEN_LO: if (byte_valid) n[7:0] <= byte_data;
        LEN_HI: begin
          if (byte_valid) begin
            n[15:8] <= byte_data;
            idx     <= '0;
            bcnt    <= '0;
          end
        end
        DATA: begin
          if (byte_valid) begin
            word <= {byte_data, word[31:8]};
            bcnt <= bcnt + 2'd1;
          end
        end
        WRITE: begin
          if (!last) begin
            idx  <= idx + 1'b1;
            bcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
